// File: rtl/pixel_controller_if.sv
// Handshake/bus bundle for pixel_controller: frame request, row acknowledge and all
// sensor-side strobes, ramp code and row readout signals.
interface pixel_controller_if #(
    parameter int unsigned NUM_ROWS = 2
);
    logic                START;
    logic                ROW_ACK;
    logic                ERASE;
    logic                EXPOSE;
    logic                RAMP;
    logic [7:0]          CONVERT_CNT;
    logic [NUM_ROWS-1:0] READ;
    logic                ROW_VALID;
    logic                BUSY;
    logic                FRAME_DONE;

    modport master (
        output START, ROW_ACK,
        input  ERASE, EXPOSE, RAMP, CONVERT_CNT, READ, ROW_VALID, BUSY, FRAME_DONE
    );

    modport slave (
        input  START, ROW_ACK,
        output ERASE, EXPOSE, RAMP, CONVERT_CNT, READ, ROW_VALID, BUSY, FRAME_DONE
    );
endinterface

// File: rtl/pixel_controller.sv
// Pixel array frame sequencer: erase, expose, ramp conversion, row-by-row readout.
// Define PIXEL_CONTROLLER_AUTO_RESTART_EN for free-running back-to-back frames.
module pixel_controller #(
    parameter int unsigned ERASE_CYCLES  = 5,
    parameter int unsigned EXPOSE_CYCLES = 255,
    parameter int unsigned NUM_ROWS      = 2
) (
    input logic              CLK,
    input logic              RESET_N,
    pixel_controller_if.slave bus
);
    localparam int unsigned CntW = 16;
    localparam int unsigned RowW = $clog2(NUM_ROWS + 1);

    typedef enum logic [2:0] {StIdle, StErase, StExpose, StConvert, StRead} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [RowW-1:0]     row_q, row_d;
    logic                valid_q, valid_d;
    logic                erase_q, erase_d;
    logic                expose_q, expose_d;
    logic                ramp_q, ramp_d;
    logic [7:0]          conv_q, conv_d;
    logic [NUM_ROWS-1:0] read_q, read_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (bus.START) begin
                    state_d = StErase;
                    cnt_d   = '0;
                end
            end
            StErase: begin
                if (cnt_q == CntW'(ERASE_CYCLES - 1)) begin
                    state_d = StExpose;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StExpose: begin
                if (cnt_q == CntW'(EXPOSE_CYCLES - 1)) begin
                    state_d = StConvert;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StConvert: begin
                if (cnt_q == 16'd511) begin
                    state_d = StRead;
                    cnt_d   = '0;
                    row_d   = '0;
                    valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRead: begin
                // row_q == NUM_ROWS marks the single FRAME_DONE cycle after the last transfer
                if (row_q == RowW'(NUM_ROWS)) begin
                    row_d   = '0;
                    valid_d = 1'b0;
`ifdef PIXEL_CONTROLLER_AUTO_RESTART_EN
                    state_d = StErase;
`else
                    state_d = StIdle;
`endif
                end else if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (bus.ROW_ACK) begin
                    valid_d = 1'b0;
                    row_d   = row_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                row_d   = '0;
                valid_d = 1'b0;
            end
        endcase

        erase_d  = (state_d == StErase);
        expose_d = (state_d == StExpose);
        ramp_d   = (state_d == StConvert) && cnt_d[0];
        conv_d   = (state_d == StConvert) ? cnt_d[8:1] : 8'd0;
        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StRead) && (row_d == RowW'(NUM_ROWS));
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            read_d[i] = (state_d == StRead) && (row_d == RowW'(i));
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            row_q    <= '0;
            valid_q  <= 1'b0;
            erase_q  <= 1'b0;
            expose_q <= 1'b0;
            ramp_q   <= 1'b0;
            conv_q   <= 8'd0;
            read_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            valid_q  <= valid_d;
            erase_q  <= erase_d;
            expose_q <= expose_d;
            ramp_q   <= ramp_d;
            conv_q   <= conv_d;
            read_q   <= read_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.ERASE       = erase_q;
    assign bus.EXPOSE      = expose_q;
    assign bus.RAMP        = ramp_q;
    assign bus.CONVERT_CNT = conv_q;
    assign bus.READ        = read_q;
    assign bus.ROW_VALID   = valid_q;
    assign bus.BUSY        = busy_q;
    assign bus.FRAME_DONE  = done_q;
endmodule

// File: tb/tb_pixel_controller.sv
// Directed self-checking bench for pixel_controller at default parameters.
// The auto-restart scenario runs only when PIXEL_CONTROLLER_AUTO_RESTART_EN is defined.
module tb_pixel_controller;
    logic CLK = 1'b0;
    logic RESET_N;
    int   cmp  = 0;
    int   errs = 0;

    pixel_controller_if #(.NUM_ROWS(2)) bus ();

    pixel_controller #(
        .ERASE_CYCLES (5),
        .EXPOSE_CYCLES(255),
        .NUM_ROWS     (2)
    ) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    task automatic pulse_start();
        @(negedge CLK);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
    endtask

    task automatic test_reset();
        RESET_N     = 1'b0;
        bus.START   = 1'b0;
        bus.ROW_ACK = 1'b0;
        repeat (3) @(negedge CLK);
        cmp++;
        if ({bus.ERASE, bus.EXPOSE, bus.RAMP, bus.CONVERT_CNT, bus.READ, bus.ROW_VALID,
             bus.BUSY, bus.FRAME_DONE} !== 16'h0) begin
            errs++;
            $display("FAIL reset_outputs: got %b %b %b %h %b %b %b %b want all 0", bus.ERASE,
                     bus.EXPOSE, bus.RAMP, bus.CONVERT_CNT, bus.READ, bus.ROW_VALID, bus.BUSY,
                     bus.FRAME_DONE);
        end
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        cmp++;
        if (bus.BUSY !== 1'b0) begin
            errs++;
            $display("FAIL idle_after_reset: BUSY got %b want 0", bus.BUSY);
        end
    endtask

    // Leaves the bench at the first READ-state sample with ROW_ACK low.
    task automatic test_frame_timing();
        int n, ovl, edges, lastcnt;
        logic prev;
        bus.ROW_ACK = 1'b0;
        pulse_start();
        n = 0; ovl = 0;
        while (bus.ERASE === 1'b1 && n < 1000) begin
            if (bus.EXPOSE !== 1'b0) ovl++;
            n++;
            @(negedge CLK);
        end
        cmp++;
        if (n != 5) begin errs++; $display("FAIL erase_len: got %0d want 5", n); end
        cmp++;
        if (bus.EXPOSE !== 1'b1) begin
            errs++; $display("FAIL expose_no_gap: EXPOSE got %b want 1", bus.EXPOSE);
        end
        n = 0;
        while (bus.EXPOSE === 1'b1 && n < 1000) begin
            if (bus.ERASE !== 1'b0) ovl++;
            n++;
            @(negedge CLK);
        end
        cmp++;
        if (n != 255) begin errs++; $display("FAIL expose_len: got %0d want 255", n); end
        cmp++;
        if (ovl != 0) begin errs++; $display("FAIL erase_expose_overlap: got %0d want 0", ovl); end
        n = 0; edges = 0; prev = 1'b0; lastcnt = 0;
        while (bus.READ === 2'b00 && n < 2000) begin
            if (bus.RAMP === 1'b1 && prev === 1'b0) edges++;
            prev    = bus.RAMP;
            lastcnt = int'(bus.CONVERT_CNT);
            n++;
            @(negedge CLK);
        end
        cmp++;
        if (n != 512) begin errs++; $display("FAIL convert_len: got %0d want 512", n); end
        cmp++;
        if (edges != 256) begin errs++; $display("FAIL ramp_edges: got %0d want 256", edges); end
        cmp++;
        if (lastcnt != 255) begin
            errs++; $display("FAIL convert_cnt_end: got %0d want 255", lastcnt);
        end
        cmp++;
        if ({bus.READ, bus.ROW_VALID, bus.RAMP, bus.CONVERT_CNT} !== {2'b01, 1'b0, 1'b0, 8'd0})
        begin
            errs++;
            $display("FAIL read_entry: READ %b VALID %b RAMP %b CNT %0d want 01 0 0 0", bus.READ,
                     bus.ROW_VALID, bus.RAMP, bus.CONVERT_CNT);
        end
    endtask

    task automatic test_ack_withheld();
        int bad = 0;
        int n;
        @(negedge CLK);
        for (int i = 0; i < 20; i++) begin
            if (bus.READ !== 2'b01 || bus.ROW_VALID !== 1'b1) bad++;
            @(negedge CLK);
        end
        cmp++;
        if (bad != 0) begin
            errs++; $display("FAIL ack_withheld_hold: %0d unstable cycles want 0", bad);
        end
        bus.ROW_ACK = 1'b1;
        n = 0;
        while (bus.FRAME_DONE !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
        bus.ROW_ACK = 1'b0;
        cmp++;
        if (n >= 100) begin errs++; $display("FAIL withheld_done: timeout waiting FRAME_DONE"); end
        @(negedge CLK);
        cmp++;
        if (bus.BUSY !== 1'b0) begin
            errs++; $display("FAIL withheld_idle: BUSY got %b want 0", bus.BUSY);
        end
    endtask

    task automatic test_readout_ack_high();
        logic [1:0] exp_read  [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00};
        logic       exp_valid [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       exp_done  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_busy  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int n = 0;
        bus.ROW_ACK = 1'b1;
        pulse_start();
        while (bus.READ === 2'b00 && n < 2000) begin @(negedge CLK); n++; end
        cmp++;
        if (n >= 2000) begin errs++; $display("FAIL readout_reach: timeout waiting READ"); end
        for (int i = 0; i < 6; i++) begin
            cmp++;
            if ({bus.READ, bus.ROW_VALID, bus.FRAME_DONE, bus.BUSY} !==
                {exp_read[i], exp_valid[i], exp_done[i], exp_busy[i]}) begin
                errs++;
                $display("FAIL readout_step%0d: READ %b VALID %b DONE %b BUSY %b want %b %b %b %b",
                         i, bus.READ, bus.ROW_VALID, bus.FRAME_DONE, bus.BUSY, exp_read[i],
                         exp_valid[i], exp_done[i], exp_busy[i]);
            end
            @(negedge CLK);
        end
        bus.ROW_ACK = 1'b0;
    endtask

    task automatic test_reset_mid_convert();
        int n = 0;
        pulse_start();
        while (bus.CONVERT_CNT !== 8'd100 && n < 2000) begin @(negedge CLK); n++; end
        cmp++;
        if (n >= 2000) begin errs++; $display("FAIL mid_reach: timeout waiting CONVERT_CNT=100"); end
        RESET_N = 1'b0;
        #1;
        cmp++;
        if ({bus.ERASE, bus.EXPOSE, bus.RAMP, bus.CONVERT_CNT, bus.READ, bus.ROW_VALID,
             bus.BUSY, bus.FRAME_DONE} !== 16'h0) begin
            errs++;
            $display("FAIL mid_reset_outputs: CNT %0d BUSY %b RAMP %b want all 0",
                     bus.CONVERT_CNT, bus.BUSY, bus.RAMP);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        cmp++;
        if (bus.BUSY !== 1'b0) begin
            errs++; $display("FAIL mid_no_autostart: BUSY got %b want 0", bus.BUSY);
        end
        bus.ROW_ACK = 1'b1;
        pulse_start();
        n = 0;
        while (bus.ERASE === 1'b1 && n < 1000) begin n++; @(negedge CLK); end
        cmp++;
        if (n != 5) begin errs++; $display("FAIL mid_restart_erase: got %0d want 5", n); end
        n = 0;
        while (bus.FRAME_DONE !== 1'b1 && n < 2000) begin @(negedge CLK); n++; end
        cmp++;
        if (n >= 2000) begin errs++; $display("FAIL mid_restart_done: timeout waiting FRAME_DONE"); end
        bus.ROW_ACK = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_ignore_inputs();
        int n = 0;
        int bad = 0;
        pulse_start();
        while (bus.EXPOSE !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
        bus.START = 1'b1;
        n = 0;
        while (bus.EXPOSE === 1'b1 && n < 1000) begin
            bus.ROW_ACK = (n == 10 || n == 11);
            if (bus.ERASE !== 1'b0) bad++;
            n++;
            @(negedge CLK);
        end
        bus.START   = 1'b0;
        bus.ROW_ACK = 1'b0;
        cmp++;
        if (n != 255) begin errs++; $display("FAIL ignore_expose_len: got %0d want 255", n); end
        cmp++;
        if (bad != 0 || bus.ERASE !== 1'b0 || bus.BUSY !== 1'b1 || bus.READ !== 2'b00) begin
            errs++;
            $display("FAIL ignore_convert: ERASE %b BUSY %b READ %b bad %0d want 0 1 00 0",
                     bus.ERASE, bus.BUSY, bus.READ, bad);
        end
        bus.ROW_ACK = 1'b1;
        n = 0;
        while (bus.FRAME_DONE !== 1'b1 && n < 2000) begin @(negedge CLK); n++; end
        bus.ROW_ACK = 1'b0;
        @(negedge CLK);
        cmp++;
        if (n >= 2000 || bus.BUSY !== 1'b0) begin
            errs++; $display("FAIL ignore_frame_end: wait %0d BUSY %b want idle", n, bus.BUSY);
        end
    endtask

    task automatic test_auto_restart();
        int n;
        bus.ROW_ACK = 1'b1;
        pulse_start();
        for (int f = 0; f < 3; f++) begin
            n = 0;
            while (bus.FRAME_DONE !== 1'b1 && n < 2000) begin @(negedge CLK); n++; end
            cmp++;
            if (n >= 2000 || bus.BUSY !== 1'b1) begin
                errs++; $display("FAIL auto_done%0d: wait %0d BUSY %b want 1", f, n, bus.BUSY);
            end
            @(negedge CLK);
            cmp++;
            if (bus.ERASE !== 1'b1 || bus.FRAME_DONE !== 1'b0) begin
                errs++;
                $display("FAIL auto_erase%0d: ERASE %b DONE %b want 1 0", f, bus.ERASE,
                         bus.FRAME_DONE);
            end
        end
        bus.ROW_ACK = 1'b0;
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    initial begin
        test_reset();
`ifdef PIXEL_CONTROLLER_AUTO_RESTART_EN
        test_auto_restart();
`else
        test_frame_timing();
        test_ack_withheld();
        test_readout_ack_high();
        test_reset_mid_convert();
        test_ignore_inputs();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule

// File: doc/pixel_controller.md
PIXEL_CONTROLLER -- requirements
Module: pixel_controller

Interface
REQ-001 SHALL have parameter ERASE_CYCLES, 5, number of cycles ERASE is held high (legal range 1..255).
REQ-002 SHALL have parameter EXPOSE_CYCLES, 255, number of cycles EXPOSE is held high (legal range 1..65535).
REQ-003 SHALL have parameter NUM_ROWS, 2, number of pixel rows read out per frame (legal range 1..16).
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET_N  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port START  input  1  frame request; sampled only in IDLE.
REQ-007 SHALL have port ROW_ACK  input  1  downstream has captured the currently driven row DATA.
REQ-008 SHALL have port ERASE  output  1  pixel erase strobe.
REQ-009 SHALL have port EXPOSE  output  1  pixel exposure window.
REQ-010 SHALL have port RAMP  output  1  ADC ramp step; each rising edge means one LSB step.
REQ-011 SHALL have port CONVERT_CNT  output  8  current ramp code.
REQ-012 SHALL have port READ  output  NUM_ROWS  one-hot row read enable, bit r enables row r.
REQ-013 SHALL have port ROW_VALID  output  1  selected row's DATA bus is settled and valid.
REQ-014 SHALL have port BUSY  output  1  high whenever the state is not IDLE.
REQ-015 SHALL have port FRAME_DONE  output  1  one-cycle pulse after the last row is acknowledged.

Function
REQ-016 SHALL implement Moore FSM states IDLE, ERASE, EXPOSE, CONVERT, READ; all outputs registered, valid the cycle after state entry.
REQ-017 SHALL leave IDLE for ERASE on the first edge where START=1; START SHALL be ignored in all other states.
REQ-018 SHALL hold ERASE=1 for exactly ERASE_CYCLES cycles, then enter EXPOSE with no gap cycle.
REQ-019 SHALL hold EXPOSE=1 for exactly EXPOSE_CYCLES cycles, then enter CONVERT; ERASE and EXPOSE SHALL never be high together.
REQ-020 SHALL in CONVERT run a 9-bit counter c from 0 to 511, with RAMP=c[0] and CONVERT_CNT=c[8:1], giving exactly 256 RAMP pulses over 512 cycles.
REQ-021 SHALL keep CONVERT_CNT=0 and RAMP=0 outside CONVERT; after c=511, RAMP SHALL return low and the state SHALL enter READ with row index r=0.
REQ-022 SHALL in READ drive READ one-hot at bit r, and raise ROW_VALID one cycle after READ[r] rises (bus settle cycle).
REQ-023 SHALL treat ROW_VALID=1 and ROW_ACK=1 on the same edge as a transfer: ROW_VALID drops, r increments, and the new READ bit is driven on the next cycle.
REQ-024 SHALL ignore ROW_ACK while ROW_VALID=0; ROW_VALID and READ SHALL hold indefinitely while ROW_ACK=0.
REQ-025 SHALL on transfer of row NUM_ROWS-1: clear READ, pulse FRAME_DONE for one cycle, and take the next state per REQ-030/031.
REQ-026 SHALL never assert more than one READ bit, and SHALL keep READ=0 outside READ.

Reset
REQ-027 SHALL on RESET_N=0 immediately force state IDLE, with all internal counters and r at 0.
REQ-028 SHALL force all outputs to 0 during reset (ERASE, EXPOSE, RAMP, CONVERT_CNT, READ, ROW_VALID, BUSY, FRAME_DONE), including when reset is asserted mid-frame.
REQ-029 SHALL leave reset with a synchronous RESET_N release, and SHALL not start a frame until START is seen in IDLE.

Configuration
REQ-030 SHALL, with macro PIXEL_CONTROLLER_AUTO_RESTART_EN defined, go from the last row transfer directly to ERASE (BUSY stays high, free-running frames).
REQ-031 SHALL, without PIXEL_CONTROLLER_AUTO_RESTART_EN, go from the last row transfer to IDLE and wait for START.

Verification
REQ-032 SHALL cover: defaults, START pulse -> ERASE high 5 cycles, EXPOSE high 255 cycles, 256 RAMP rising edges, CONVERT_CNT ending at 255.
REQ-033 SHALL cover: READ with ROW_ACK tied high -> READ=01 then 10, each ROW_VALID high 1 cycle after settle, FRAME_DONE pulse 1 cycle, BUSY low next cycle.
REQ-034 SHALL cover: ROW_ACK withheld 20 cycles on row 0 -> READ=01 and ROW_VALID=1 stable for all 20 cycles, no advance.
REQ-035 SHALL cover: RESET_N low at CONVERT_CNT=100 -> all outputs 0 at once; a later START runs a full frame from ERASE.
REQ-036 SHALL cover: START held high during EXPOSE -> no effect; ROW_ACK pulsed in EXPOSE -> no effect.
REQ-037 SHALL cover: PIXEL_CONTROLLER_AUTO_RESTART_EN defined, START once -> ERASE rises the cycle after FRAME_DONE, across 3 consecutive frames.
